// File: rtl/bk_add_arbiter_if.sv
// Bundle of the request, response and adder-side signals of bk_add_arbiter.
//   slave  : the arbiter itself (accepts requests, drives responses and add_in)
//   master : the surrounding environment (clients plus the adder instance)
// Signals:
//   req_valid/req_ready  per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b          packed operands, requester i at [i*OP_W +: OP_W]
//   rsp_valid/rsp_ready  result handshake
//   rsp_id/rsp_sum       owner index and 13-bit sum of the result
//   add_in/add_out       interleaved operand bus to the adder and its result
interface bk_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 12
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [OP_W:0]           rsp_sum;
    logic [2*OP_W-1:0]       add_in;
    logic [OP_W:0]           add_out;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_out,
        output req_ready, rsp_valid, rsp_id, rsp_sum, add_in
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_out,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, add_in
    );
endinterface

// File: rtl/bk_add_arbiter.sv
// Round-robin arbiter that shares one combinational 12-bit adder among
// NUM_REQ requesters, one transaction in flight at a time.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  bk_add_arbiter_if.slave: request handshake and operands, response
//        handshake with id/sum, interleaved adder operand bus and adder result
// Flow: IDLE grants and registers operands, EXEC captures the adder output,
// RESP holds the result until rsp_ready.
module bk_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    bk_add_arbiter_if.slave    bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Requester count at ID_W+1 bits so modulo arithmetic cannot overflow.
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [2*OP_W-1:0]   add_in_q, add_in_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [OP_W:0]       rsp_sum_q, rsp_sum_d;

    logic [NUM_REQ-1:0]  req_ready_s;
    logic [ID_W-1:0]     winner_s;
    logic                found_s;
    logic [ID_W:0]       idx_s;
    logic [ID_W:0]       ptr_inc_s;

    // Adder wants a and b bit-interleaved: even positions a, odd positions b.
    function automatic logic [2*OP_W-1:0] interleave(input logic [OP_W-1:0] a,
                                                     input logic [OP_W-1:0] b);
        logic [2*OP_W-1:0] r;
        r = '0;
        for (int k = 0; k < OP_W; k++) begin
            r[2*k]   = a[k];
            r[2*k+1] = b[k];
        end
        return r;
    endfunction

    // Winner search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            idx_s = (idx_s >= NUM_REQ_W) ? (idx_s - NUM_REQ_W) : idx_s;
            winner_s = (!found_s && bus.req_valid[idx_s[ID_W-1:0]]) ? idx_s[ID_W-1:0] : winner_s;
            found_s  = found_s | bus.req_valid[idx_s[ID_W-1:0]];
        end
    end

    // Pointer moves one past the winner so the winner gets lowest priority next.
    always_comb begin
        ptr_inc_s = {1'b0, winner_s} + {{ID_W{1'b0}}, 1'b1};
    end

    // Next-state and grant logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        add_in_d    = add_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        req_ready_s = '0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    req_ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
                    add_in_d    = interleave(bus.req_a[winner_s*OP_W +: OP_W],
                                             bus.req_b[winner_s*OP_W +: OP_W]);
                    id_d        = winner_s;
                    rr_ptr_d    = (ptr_inc_s >= NUM_REQ_W) ? '0 : ptr_inc_s[ID_W-1:0];
                    state_d     = EXEC;
                end else begin
                    state_d     = IDLE;
                end
            end
            EXEC: begin
                // add_in has been stable for a full cycle, so add_out is settled.
                rsp_sum_d   = bus.add_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            add_in_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            add_in_q    <= add_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.add_in    = add_in_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_bk_add_arbiter.sv
// Directed and randomised bench for bk_add_arbiter with a behavioural adder.
module tb_bk_add_arbiter;
    localparam int NUM_REQ = 4;
    localparam int OP_W    = 12;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    bk_add_arbiter_if #(.NUM_REQ(NUM_REQ), .OP_W(OP_W)) bus ();

    bk_add_arbiter #(.NUM_REQ(NUM_REQ), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder: de-interleave INPUTS and add to a 13-bit OUTS.
    always_comb begin
        logic [OP_W-1:0] aa;
        logic [OP_W-1:0] bb;
        aa = '0;
        bb = '0;
        for (int k = 0; k < OP_W; k++) begin
            aa[k] = bus.add_in[2*k];
            bb[k] = bus.add_in[2*k+1];
        end
        bus.add_out = {1'b0, aa} + {1'b0, bb};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*OP_W-1:0] ilv(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        logic [2*OP_W-1:0] r;
        for (int k = 0; k < OP_W; k++) begin
            r[2*k]   = a[k];
            r[2*k+1] = b[k];
        end
        return r;
    endfunction

    task automatic set_ops(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        bus.req_a[i*OP_W +: OP_W] = a;
        bus.req_b[i*OP_W +: OP_W] = b;
    endtask

    // One isolated transaction: grant, 2-cycle latency, result, handshake.
    task automatic do_txn(input string tag, input int idx, input logic [OP_W-1:0] a,
                          input logic [OP_W-1:0] b, input logic [OP_W:0] exp_sum);
        int  n;
        logic got;
        @(negedge clk);
        set_ops(idx, a, b);
        bus.req_valid = 4'b0001 << idx;
        #1;
        check_eq({tag, "_gnt"}, 32'(bus.req_ready), 32'(4'b0001 << idx));
        @(posedge clk);
        #1 bus.req_valid = '0;
        n = 0;
        got = 1'b0;
        while (!got && n < 6) begin
            @(negedge clk);
            n++;
            if (n == 1) check_eq({tag, "_addin"}, 32'(bus.add_in), 32'(ilv(a, b)));
            got = bus.rsp_valid;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'd2);
        check_eq({tag, "_sum"}, 32'(bus.rsp_sum), 32'(exp_sum));
        check_eq({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [OP_W-1:0] t2_a [4] = '{12'hFFF, 12'h123, 12'h800, 12'h555};
    logic [OP_W-1:0] t2_b [4] = '{12'h001, 12'h321, 12'h800, 12'hAAA};
    logic [OP_W:0]   t2_s [4] = '{13'h1000, 13'h0444, 13'h1000, 13'h0FFF};

    initial begin
        int ngnt, nrsp, last, n, g, maxw;
        int waits [NUM_REQ];
        logic got;
        logic [1:0]    exp_id_q [$];
        logic [OP_W:0] exp_sum_q [$];
        logic [OP_W-1:0] ra [NUM_REQ];
        logic [OP_W-1:0] rb [NUM_REQ];

        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_id", 32'(bus.rsp_id), 32'd0);
        check_eq("rst_sum", 32'(bus.rsp_sum), 32'd0);
        check_eq("rst_addin", 32'(bus.add_in), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);

        // 1: carry-out case from requester 0
        do_txn("t1", 0, 12'hFFF, 12'h001, 13'h1000);

        // 2: all requesters valid, rsp_ready high, order 0,1,2,3,0 every 3 cycles
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_ops(i, t2_a[i], t2_b[i]);
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        ngnt = 0;
        nrsp = 0;
        last = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (bus.req_ready != '0) begin
                check_eq("t2_gnt", 32'(bus.req_ready), 32'(4'b0001 << (ngnt % 4)));
                if (ngnt > 0) check_eq("t2_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                ngnt++;
            end
            if (bus.rsp_valid) begin
                check_eq("t2_id", 32'(bus.rsp_id), 32'(nrsp % 4));
                check_eq("t2_sum", 32'(bus.rsp_sum), 32'(t2_s[nrsp % 4]));
                nrsp++;
                if (nrsp == 5) begin
                    bus.req_valid = '0;
                    break;
                end
            end
        end
        check_eq("t2_count", 32'(nrsp), 32'd5);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;

        // 3: backpressure with requester 0 waiting, nothing granted
        @(negedge clk);
        set_ops(2, 12'hABC, 12'h544);
        bus.req_valid = 4'b0100;
        #1 check_eq("t3_gnt", 32'(bus.req_ready), 32'h4);
        @(posedge clk);
        #1 bus.req_valid = 4'b0001;
        n = 0;
        got = 1'b0;
        while (!got && n < 6) begin
            @(negedge clk);
            n++;
            got = bus.rsp_valid;
        end
        check_eq("t3_lat", 32'(n), 32'd2);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            check_eq("t3_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("t3_sum", 32'(bus.rsp_sum), 32'h1000);
            check_eq("t3_id", 32'(bus.rsp_id), 32'd2);
            check_eq("t3_noready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_hs", 32'(bus.rsp_valid), 32'd0);
        check_eq("t3_idle", 32'(bus.req_ready), 32'd0);

        // 4: no carry-out, then zero operands
        do_txn("t4a", 1, 12'h7FF, 12'h7FF, 13'h0FFE);
        do_txn("t4b", 3, 12'h000, 12'h000, 13'h0000);

        // 5: reset in EXEC discards the transaction and clears the pointer
        @(negedge clk);
        bus.req_valid = 4'b1100;
        #1 check_eq("t5_gnt", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        check_eq("t5_exec", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("t5_ptr", 32'(bus.req_ready), 32'h4);
        check_eq("t5_sum", 32'(bus.rsp_sum), 32'd0);
        check_eq("t5_addin", 32'(bus.add_in), 32'd0);
        bus.req_valid = '0;
        for (int j = 0; j < 3; j++) begin
            check_eq("t5_norsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end

        // 6: random operands, valids and backpressure
        for (int i = 0; i < NUM_REQ; i++) begin
            ra[i] = 12'($urandom);
            rb[i] = 12'($urandom);
            set_ops(i, ra[i], rb[i]);
            waits[i] = 0;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 4'($urandom);
        bus.rsp_ready = ($urandom_range(3) != 0);
        nrsp = 0;
        for (int cyc = 0; cyc < 90000 && nrsp < 10000; cyc++) begin
            @(negedge clk);
            g = -1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_id_q.size() == 0) begin
                    check_eq("t6_unexpected", 32'd0, 32'd1);
                end else begin
                    check_eq("t6_id", 32'(bus.rsp_id), 32'(exp_id_q.pop_front()));
                    check_eq("t6_sum", 32'(bus.rsp_sum), 32'(exp_sum_q.pop_front()));
                end
                nrsp++;
            end
            if (bus.req_ready != '0) begin
                check_eq("t6_gnt_ok",
                         32'($onehot(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0)), 32'd1);
                for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) g = i;
                if (g >= 0) begin
                    exp_id_q.push_back(2'(g));
                    exp_sum_q.push_back({1'b0, ra[g]} + {1'b0, rb[g]});
                    maxw = 0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (i == g) waits[i] = 0;
                        else if (bus.req_valid[i]) waits[i]++;
                        else waits[i] = 0;
                        if (waits[i] > maxw) maxw = waits[i];
                    end
                    check_eq("t6_starve", 32'(maxw < NUM_REQ), 32'd1);
                end
            end
            @(posedge clk);
            #1;
            if (g >= 0) begin
                ra[g] = 12'($urandom);
                rb[g] = 12'($urandom);
                set_ops(g, ra[g], rb[g]);
            end
            bus.req_valid = 4'($urandom);
            bus.rsp_ready = ($urandom_range(3) != 0);
        end
        check_eq("t6_count", 32'(nrsp), 32'd10000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
